// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx (start/busy handshake) between NUM_REQ
// byte sources. Round-robin grant; a granted source may send up to MAX_BURST
// back-to-back bytes before the grant rotates. A launch that never sees
// tx_busy rise within ACK_TIMEOUT cycles is abandoned.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transfer; arbitrate among req_valid from last_grant+1
// SEND      | one cycle: raise tx_start and req_ready[grant_id] next edge
// WAIT_ACK  | waiting for uart_tx to accept (tx_busy high) or timeout
// WAIT_DONE | uart_tx busy; on fall, continue burst or release grant
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 4,
  parameter int ACK_TIMEOUT = 16,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [GW-1:0]        grant_id,
  output logic                 active
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [AW-1:0] ACK_LOAD   = AW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [BW-1:0]   burst_cnt;
  logic [AW-1:0]   ack_cnt;
  logic [7:0]      req_bytes [NUM_REQ];
  logic            arb_hit;
  logic [GW-1:0]   arb_idx;

  // unpack the flat request bus into one byte per requester
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[8*i +: 8];
    end
  end

  // round-robin pick: scan downward so the index nearest after last_grant
  // is assigned last and wins; all indices resolved in a single cycle
  always_comb begin
    int          idx;
    logic [GW-1:0] idx_c;
    arb_hit = 1'b0;
    arb_idx = '0;
    idx     = 0;
    idx_c   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx   = (int'(last_grant) + k) % NUM_REQ;
      idx_c = GW'(idx);
      if (req_valid[idx_c]) begin
        arb_hit = 1'b1;
        arb_idx = idx_c;
      end
    end
  end

  assign active = (state != IDLE);

  // sequencing FSM with registered launch/consume pulses; the ack timer is a
  // down-counter loaded on launch and expiring at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      burst_cnt  <= '0;
      ack_cnt    <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      tx_start  <= 1'b0;
      req_ready <= '0;
      unique case (state)
        IDLE: begin
          if (arb_hit) begin
            tx_data   <= req_bytes[arb_idx];
            grant_id  <= arb_idx;
            burst_cnt <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          tx_start  <= 1'b1;
          req_ready <= NUM_REQ'(1) << grant_id;
          ack_cnt   <= ACK_LOAD;
          state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == '0) begin
            // byte already consumed from the requester; it is simply lost
            last_grant <= grant_id;
            state      <= IDLE;
          end else begin
            ack_cnt <= ack_cnt - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (req_valid[grant_id] && (burst_cnt < BURST_LAST)) begin
              burst_cnt <= burst_cnt + 1'b1;
              tx_data   <= req_bytes[grant_id];
              state     <= SEND;
            end else begin
              last_grant <= grant_id;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of the round-robin uart_tx arbiter with
// a per-requester byte queue model and a simple tx_busy responder.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .ACK_TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [7:0] mem [4][16];
  int head [4];
  int tail [4];
  int ready_cnt [4];
  int multi_ready;

  int launch_id [16];
  int launch_data [16];
  int nl;

  int exp_id [8];
  int exp_data [8];

  logic busy_en;
  int   busy_len;
  int   busy_left;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (head[i] != tail[i]);
      req_data[8*i +: 8] = mem[i][head[i] % 16];
    end
  endtask

  task automatic push(input int i, input int b);
    mem[i][tail[i] % 16] = 8'(b);
    tail[i]++;
    refresh();
  endtask

  // advance one clock; sample away from the edge, pop consumed bytes,
  // log launches and model the uart_tx busy response
  task automatic step();
    @(posedge clk);
    #1;
    if ($countones(req_ready) > 1) multi_ready++;
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) begin
        ready_cnt[i]++;
        if (head[i] != tail[i]) head[i]++;
      end
    end
    if (tx_start && nl < 16) begin
      launch_id[nl]   = int'(grant_id);
      launch_data[nl] = int'(tx_data);
      nl++;
    end
    if (tx_busy && busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
    if (busy_en && tx_start) begin
      tx_busy   = 1'b1;
      busy_left = busy_len;
    end
    refresh();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      head[i]      = 0;
      tail[i]      = 0;
      ready_cnt[i] = 0;
    end
    tx_busy   = 1'b0;
    busy_left = 0;
    nl        = 0;
    refresh();
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    clear_model();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_launch(input string tag, input int max_cyc);
    int k;
    k = 0;
    step();
    while (!tx_start && k < max_cyc) begin
      step();
      k++;
    end
    check(tag, int'(k < max_cyc), 1);
  endtask

  task automatic run_until_done(input string tag, input int want, input int max_cyc);
    int k;
    k = 0;
    while (!(nl >= want && !active) && k < max_cyc) begin
      step();
      k++;
    end
    check(tag, int'(k < max_cyc), 1);
  endtask

  task automatic verify(input string tag, input int n);
    check({tag, "_count"}, nl, n);
    for (int i = 0; i < n && i < nl; i++) begin
      check($sformatf("%s_%0d", tag, i), (launch_id[i] << 8) | launch_data[i],
            (exp_id[i] << 8) | exp_data[i]);
    end
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    multi_ready = 0;
    busy_en     = 1'b1;
    busy_len    = 10;
    req_valid   = '0;
    req_data    = '0;
    rst         = 1'b1;
    clear_model();
    step();
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_active", int'(active), 0);
    rst = 1'b0;
    step();

    // single requester: latency, launch contents, busy handshake, return to idle
    push(0, 8'hA5);
    step();
    check("t1_send_no_start", int'(tx_start), 0);
    check("t1_send_active", int'(active), 1);
    step();
    check("t1_tx_start", int'(tx_start), 1);
    check("t1_tx_data", int'(tx_data), 8'hA5);
    check("t1_req_ready", int'(req_ready), 4'b0001);
    check("t1_grant_id", int'(grant_id), 0);
    step();
    check("t1_start_pulse", int'(tx_start), 0);
    check("t1_ready_pulse", int'(req_ready), 0);
    repeat (9) step();
    check("t1_busy_active", int'(active), 1);
    step();
    check("t1_idle_active", int'(active), 0);

    // all four requesters: rotation 0,1,2,3 then wrap to 0 ahead of 2
    do_reset();
    busy_len = 3;
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13);
    run_until_done("t2_done_a", 4, 200);
    push(2, 8'h15); push(0, 8'h14);
    run_until_done("t2_done_b", 6, 200);
    exp_id = '{0, 1, 2, 3, 0, 2, 0, 0};
    exp_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 0, 0};
    verify("t2", 6);

    // burst cap: four bytes from 1, grant rotates to 2, then 1 finishes
    do_reset();
    busy_len = 3;
    for (int b = 0; b < 5; b++) push(1, 8'h21 + b);
    push(2, 8'h30);
    run_until_done("t3_done", 6, 300);
    exp_id = '{1, 1, 1, 1, 2, 1, 0, 0};
    exp_data = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h30, 8'h25, 0, 0};
    verify("t3", 6);

    // ack timeout: busy never rises, back to IDLE 16 cycles after tx_start
    do_reset();
    busy_en = 1'b0;
    push(0, 8'h40);
    push(3, 8'h43);
    wait_launch("t4_launch0", 20);
    check("t4_grant0", int'(grant_id), 0);
    repeat (15) step();
    check("t4_still_waiting", int'(active), 1);
    step();
    check("t4_timeout_idle", int'(active), 0);
    check("t4_ready0_once", ready_cnt[0], 1);
    wait_launch("t4_launch3", 20);
    check("t4_grant3", int'(grant_id), 3);
    check("t4_data3", int'(tx_data), 8'h43);
    run_until_done("t4_done", 2, 60);

    // tx_busy already high before launch: WAIT_ACK exits at once, then waits
    do_reset();
    busy_en = 1'b0;
    tx_busy = 1'b1;
    push(0, 8'h77);
    wait_launch("t6_launch", 20);
    repeat (20) step();
    check("t6_hold_while_busy", int'(active), 1);
    tx_busy = 1'b0;
    step();
    check("t6_release", int'(active), 0);

    // async reset mid WAIT_DONE, then arbitration restarts from requester 0
    do_reset();
    busy_en  = 1'b1;
    busy_len = 6;
    push(2, 8'h52);
    run_until_done("t5_first", 1, 60);
    busy_len = 20;
    push(2, 8'h53);
    wait_launch("t5_launch", 20);
    repeat (5) step();
    check("t5_pre_active", int'(active), 1);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_tx_start", int'(tx_start), 0);
    check("t5_async_req_ready", int'(req_ready), 0);
    check("t5_async_tx_data", int'(tx_data), 0);
    check("t5_async_grant_id", int'(grant_id), 0);
    check("t5_async_active", int'(active), 0);
    clear_model();
    step();
    step();
    rst = 1'b0;
    step();
    busy_len = 4;
    push(3, 8'h63);
    push(1, 8'h61);
    run_until_done("t5_done", 2, 200);
    exp_id = '{1, 3, 0, 0, 0, 0, 0, 0};
    exp_data = '{8'h61, 8'h63, 0, 0, 0, 0, 0, 0};
    verify("t5", 2);

    check("one_hot_ready", multi_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
